// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// byte-lane / word-address constants.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned BeWidth   = 4;
  localparam int unsigned WordShift = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with one synchronous read/write port, per-byte write
// enables and a registered read result. Contents are not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [BeWidth-1:0] be_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned i = 0; i < BeWidth; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the LSU port: accepts one request, stalls for
// WAIT_CYCLES, then returns load data or a store acknowledge.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;

  logic        accept;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, cur_off;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic        enter_resp;
  logic        mem_en;
  logic [31:0] mem_rdata;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // In IDLE the live request drives the array so a zero-wait build can
  // commit/read on the accept edge itself.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_off = cur_addr - BASE_ADDR;
    cur_err = (cur_addr[1:0] != 2'b00) || ((cur_off >> WordShift) >= 32'(DEPTH_WORDS));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'd0;
          end
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) state_d = StResp;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_load_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
      rsp_load_d  = !cur_we && !cur_err;
    end
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  assign mem_en     = enter_resp && !cur_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  dmem_array #(
    .Depth (DEPTH_WORDS),
    .AddrW (AddrW)
  ) u_array (
    .clk_i   (clock),
    .en_i    (mem_en),
    .we_i    (cur_we),
    .be_i    (cur_be),
    .addr_i  (cur_off[AddrW+WordShift-1:WordShift]),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  // Array read register holds its value until the next access, so gating it
  // with a registered flag keeps the response stable under backpressure.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? mem_rdata : 32'd0;

endmodule
